// File: rtl/cpu_pkg.sv
// Shared definitions for the Phase-1 CPU: opcodes, ALU codes, IR fields
// and the control sequencer state encoding.
package cpu_pkg;

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_ADDI = 5'b00001;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_SHL  = 5'b00111;
    localparam logic [4:0] OP_SHR  = 5'b01000;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    localparam logic [3:0] ALU_OR  = 4'd0;
    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_ADD = 4'd2;
    localparam logic [3:0] ALU_SUB = 4'd3;
    localparam logic [3:0] ALU_SHL = 4'd4;
    localparam logic [3:0] ALU_SHR = 4'd5;

    localparam int OP_MSB = 31;
    localparam int OP_W   = 5;
    localparam int RA_MSB = 26;
    localparam int RB_MSB = 22;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3,
        S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        K_RTYPE, K_ADDI, K_LD, K_NOP, K_HALT, K_ILL
    } kind_t;

    function automatic kind_t kind_of(input logic [4:0] op);
        case (op)
            OP_LD:   kind_of = K_LD;
            OP_ADDI: kind_of = K_ADDI;
            OP_ADD, OP_SUB, OP_AND,
            OP_OR, OP_SHL, OP_SHR: kind_of = K_RTYPE;
            OP_NOP:  kind_of = K_NOP;
            OP_HALT: kind_of = K_HALT;
            default: kind_of = K_ILL;
        endcase
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            OP_AND:  alu_of = ALU_AND;
            OP_ADD:  alu_of = ALU_ADD;
            OP_SUB:  alu_of = ALU_SUB;
            OP_SHL:  alu_of = ALU_SHL;
            OP_SHR:  alu_of = ALU_SHR;
            default: alu_of = ALU_OR;
        endcase
    endfunction

endpackage

// File: rtl/reg_decoder_4to16.sv
// Register index decoder: index plus enable to a one-hot select,
// all-zero when disabled.
module reg_decoder_4to16 #(
    parameter int N = 16
) (
    input  logic [$clog2(N)-1:0] idx,
    input  logic                 en,
    output logic [N-1:0]         y
);

    always_comb begin
        y = '0;
        if (en) y[idx] = 1'b1;
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired T0-T7 control sequencer for the Phase-1 datapath.
// State is registered; strobes are a Moore decode of state and IR.
module control_unit
    import cpu_pkg::*;
#(
    parameter int NREGS  = 16,
    parameter int CWIDTH = 19
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [31:0]      IR,
    input  logic             Stop,
    output logic [NREGS-1:0] Rin,
    output logic [NREGS-1:0] Rout,
    output logic             PCin,
    output logic             PCout,
    output logic             MARin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             IRin,
    output logic             Yin,
    output logic             Zlowin,
    output logic             Zlowout,
    output logic             IncPC,
    output logic             Read,
    output logic             Cout,
    output logic [3:0]       ALUop,
    output logic             Run,
    output logic             Illegal
);

    localparam int RW = $clog2(NREGS);

    state_t          state;
    state_t          fetch_next;
    kind_t           kind;
    logic [OP_W-1:0] op;
    logic [RW-1:0]   ra;
    logic [RW-1:0]   rb;
    logic [RW-1:0]   rc;
    logic [RW-1:0]   rin_idx;
    logic [RW-1:0]   rout_idx;
    logic            rin_en;
    logic            rout_en;
    logic            unused_ir;

    assign op        = IR[OP_MSB -: OP_W];
    assign ra        = IR[RA_MSB -: RW];
    assign rb        = IR[RB_MSB -: RW];
    assign rc        = IR[CWIDTH-1 -: RW];
    assign unused_ir = ^IR[CWIDTH-RW-1:0];
    assign kind      = kind_of(op);

    // Every edge that would start a new fetch honours a pending Stop.
    assign fetch_next = Stop ? S_HALT : S_T0;

    always_ff @(posedge clock) begin
        if (!clear_n) begin
            state   <= S_RST;
            Illegal <= 1'b0;
        end else begin
            unique case (state)
                S_RST: state <= fetch_next;
                S_T0:  state <= S_T1;
                S_T1:  state <= S_T2;
                S_T2:  state <= S_T3;
                S_T3: begin
                    unique case (kind)
                        K_RTYPE, K_ADDI, K_LD: state <= S_T4;
                        K_NOP:   state <= fetch_next;
                        default: state <= S_HALT;
                    endcase
                    if (kind == K_ILL) Illegal <= 1'b1;
                end
                S_T4:   state <= S_T5;
                S_T5:   state <= (kind == K_LD) ? S_T6 : fetch_next;
                S_T6:   state <= S_T7;
                S_T7:   state <= fetch_next;
                S_HALT: state <= S_HALT;
                default: state <= S_RST;
            endcase
        end
    end

    assign Run = (state != S_RST) && (state != S_HALT);

    always_comb begin
        PCin     = 1'b0;
        PCout    = 1'b0;
        MARin    = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zlowin   = 1'b0;
        Zlowout  = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        Cout     = 1'b0;
        ALUop    = ALU_OR;
        rin_en   = 1'b0;
        rout_en  = 1'b0;
        rin_idx  = ra;
        rout_idx = rb;
        unique case (state)
            S_T0: begin
                PCout  = 1'b1;
                MARin  = 1'b1;
                IncPC  = 1'b1;
                Zlowin = 1'b1;
            end
            S_T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (kind inside {K_RTYPE, K_ADDI, K_LD}) begin
                    rout_en = 1'b1;
                    Yin     = 1'b1;
                end
            end
            S_T4: begin
                if (kind == K_RTYPE) begin
                    rout_en  = 1'b1;
                    rout_idx = rc;
                    ALUop    = alu_of(op);
                    Zlowin   = 1'b1;
                end else if (kind inside {K_ADDI, K_LD}) begin
                    Cout   = 1'b1;
                    ALUop  = ALU_ADD;
                    Zlowin = 1'b1;
                end
            end
            S_T5: begin
                if (kind == K_LD) begin
                    Zlowout = 1'b1;
                    MARin   = 1'b1;
                end else if (kind inside {K_RTYPE, K_ADDI}) begin
                    Zlowout = 1'b1;
                    rin_en  = 1'b1;
                end
            end
            S_T6: begin
                Read  = 1'b1;
                MDRin = 1'b1;
            end
            S_T7: begin
                MDRout = 1'b1;
                rin_en = 1'b1;
            end
            default: ;
        endcase
    end

    reg_decoder_4to16 #(.N(NREGS)) u_rin_dec (
        .idx (rin_idx),
        .en  (rin_en),
        .y   (Rin)
    );

    reg_decoder_4to16 #(.N(NREGS)) u_rout_dec (
        .idx (rout_idx),
        .en  (rout_en),
        .y   (Rout)
    );

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: a small behavioural datapath closes the loop
// so register results can be checked alongside the per-cycle strobes.
module tb_control_unit;

    logic        clock;
    logic        clear_n;
    logic [31:0] IR;
    logic        Stop;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic        PCin, PCout, MARin, MDRin, MDRout, IRin;
    logic        Yin, Zlowin, Zlowout, IncPC, Read, Cout;
    logic [3:0]  ALUop;
    logic        Run;
    logic        Illegal;

    control_unit #(.NREGS(16), .CWIDTH(19)) dut (
        .clock   (clock),
        .clear_n (clear_n),
        .IR      (IR),
        .Stop    (Stop),
        .Rin     (Rin),
        .Rout    (Rout),
        .PCin    (PCin),
        .PCout   (PCout),
        .MARin   (MARin),
        .MDRin   (MDRin),
        .MDRout  (MDRout),
        .IRin    (IRin),
        .Yin     (Yin),
        .Zlowin  (Zlowin),
        .Zlowout (Zlowout),
        .IncPC   (IncPC),
        .Read    (Read),
        .Cout    (Cout),
        .ALUop   (ALUop),
        .Run     (Run),
        .Illegal (Illegal)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    localparam logic [13:0] B_PCIN   = 14'h2000;
    localparam logic [13:0] B_PCOUT  = 14'h1000;
    localparam logic [13:0] B_MARIN  = 14'h0800;
    localparam logic [13:0] B_MDRIN  = 14'h0400;
    localparam logic [13:0] B_MDROUT = 14'h0200;
    localparam logic [13:0] B_IRIN   = 14'h0100;
    localparam logic [13:0] B_YIN    = 14'h0080;
    localparam logic [13:0] B_ZIN    = 14'h0040;
    localparam logic [13:0] B_ZOUT   = 14'h0020;
    localparam logic [13:0] B_INC    = 14'h0010;
    localparam logic [13:0] B_READ   = 14'h0008;
    localparam logic [13:0] B_COUT   = 14'h0004;
    localparam logic [13:0] B_RUN    = 14'h0002;
    localparam logic [13:0] B_ILL    = 14'h0001;

    localparam logic [13:0] F0 = B_PCOUT | B_MARIN | B_INC | B_ZIN | B_RUN;
    localparam logic [13:0] F1 = B_ZOUT | B_PCIN | B_READ | B_MDRIN | B_RUN;
    localparam logic [13:0] F2 = B_MDROUT | B_IRIN | B_RUN;

    localparam logic [31:0] I_OR   = 32'h312B0000;
    localparam logic [31:0] I_ADDI = 32'h09A7FFFB;
    localparam logic [31:0] I_LD   = 32'h00B80010;
    localparam logic [31:0] I_NOP  = 32'hD0000000;
    localparam logic [31:0] I_HALT = 32'hD8000000;
    localparam logic [31:0] I_ILL  = 32'hF8000000;
    // add R1,R2,R3
    localparam logic [31:0] I_ADD  = {5'b00011, 4'd1, 4'd2, 4'd3, 15'd0};

    // Behavioural datapath
    logic [31:0] R [16];
    logic [31:0] mem [256];
    logic [31:0] PC, MAR, MDR, Y, Z, bus, alu_res;
    logic        poke_r, poke_m;
    logic [7:0]  poke_idx;
    logic [31:0] poke_val;

    always_comb begin
        bus = 32'h0;
        if (PCout)        bus = PC;
        else if (MDRout)  bus = MDR;
        else if (Zlowout) bus = Z;
        else if (Cout)    bus = {{13{IR[18]}}, IR[18:0]};
        else begin
            for (int i = 0; i < 16; i++)
                if (Rout[i]) bus = R[i];
        end
    end

    always_comb begin
        case (ALUop)
            4'd0:    alu_res = Y | bus;
            4'd1:    alu_res = Y & bus;
            4'd2:    alu_res = Y + bus;
            4'd3:    alu_res = Y - bus;
            4'd4:    alu_res = Y << bus[4:0];
            4'd5:    alu_res = Y >> bus[4:0];
            default: alu_res = 32'h0;
        endcase
    end

    always @(posedge clock) begin
        if (poke_r) R[poke_idx[3:0]] <= poke_val;
        if (poke_m) mem[poke_idx] <= poke_val;
        if (!clear_n) PC <= 32'h0;
        else if (PCin) PC <= bus;
        for (int i = 0; i < 16; i++)
            if (Rin[i]) R[i] <= bus;
        if (MARin) MAR <= bus;
        if (MDRin) MDR <= Read ? mem[MAR[7:0]] : bus;
        if (Yin) Y <= bus;
        if (Zlowin) Z <= IncPC ? bus + 32'd1 : alu_res;
    end

    logic mon;
    logic rin_seen;
    always @(negedge clock)
        if (mon && Rin != 16'h0) rin_seen <= 1'b1;

    typedef struct {
        logic [31:0] ir;
        logic [13:0] strb;
        logic [15:0] rin;
        logic [15:0] rout;
        logic [3:0]  alu;
    } vec_t;

    vec_t tbl[$];
    int checks = 0;
    int errors = 0;

    function automatic logic [13:0] strb_now();
        return {PCin, PCout, MARin, MDRin, MDRout, IRin, Yin,
                Zlowin, Zlowout, IncPC, Read, Cout, Run, Illegal};
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic void add(input logic [31:0] ir, input logic [13:0] s,
                                input logic [15:0] ri, input logic [15:0] ro,
                                input logic [3:0] alu);
        tbl.push_back('{ir, s, ri, ro, alu});
    endfunction

    function automatic void add_fetch(input logic [31:0] ir);
        add(ir, F0, 16'h0, 16'h0, 4'd0);
        add(ir, F1, 16'h0, 16'h0, 4'd0);
        add(ir, F2, 16'h0, 16'h0, 4'd0);
    endfunction

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic poke(input logic reg_not_mem, input logic [7:0] idx,
                        input logic [31:0] val);
        poke_r   = reg_not_mem;
        poke_m   = !reg_not_mem;
        poke_idx = idx;
        poke_val = val;
        @(posedge clock);
        #1;
        poke_r = 1'b0;
        poke_m = 1'b0;
    endtask

    // Hold clear_n low across exactly one edge, then release.
    task automatic pulse_reset();
        @(negedge clock);
        clear_n = 1'b0;
        @(posedge clock);
        #1;
        clear_n = 1'b1;
        @(negedge clock);
    endtask

    initial begin
        clear_n  = 1'b0;
        Stop     = 1'b0;
        IR       = 32'h0;
        poke_r   = 1'b0;
        poke_m   = 1'b0;
        poke_idx = 8'h0;
        poke_val = 32'h0;
        mon      = 1'b0;
        rin_seen = 1'b0;

        for (int i = 0; i < 16; i++) poke(1'b1, 8'(i), 32'h0);
        poke(1'b1, 8'd5, 32'h34);
        poke(1'b1, 8'd6, 32'h45);
        poke(1'b1, 8'd4, 32'h10);
        poke(1'b1, 8'd7, 32'h20);
        poke(1'b0, 8'h30, 32'hCAFE);

        @(negedge clock);
        check("reset strobes", 32'(strb_now()), 32'h0);
        check("reset rin/rout", {Rin, Rout}, 32'h0);
        check("reset aluop", 32'(ALUop), 32'h0);

        add_fetch(I_OR);
        add(I_OR,   B_YIN | B_RUN,   16'h0,    16'h0020, 4'd0);
        add(I_OR,   B_ZIN | B_RUN,   16'h0,    16'h0040, 4'd0);
        add(I_OR,   B_ZOUT | B_RUN,  16'h0004, 16'h0,    4'd0);
        add_fetch(I_ADDI);
        add(I_ADDI, B_YIN | B_RUN,   16'h0,    16'h0010, 4'd0);
        add(I_ADDI, B_COUT | B_ZIN | B_RUN, 16'h0, 16'h0, 4'd2);
        add(I_ADDI, B_ZOUT | B_RUN,  16'h0008, 16'h0,    4'd0);
        add_fetch(I_LD);
        add(I_LD,   B_YIN | B_RUN,   16'h0,    16'h0080, 4'd0);
        add(I_LD,   B_COUT | B_ZIN | B_RUN, 16'h0, 16'h0, 4'd2);
        add(I_LD,   B_ZOUT | B_MARIN | B_RUN, 16'h0, 16'h0, 4'd0);
        add(I_LD,   B_READ | B_MDRIN | B_RUN, 16'h0, 16'h0, 4'd0);
        add(I_LD,   B_MDROUT | B_RUN, 16'h0002, 16'h0,   4'd0);
        add_fetch(I_NOP);
        add(I_NOP,  B_RUN,           16'h0,    16'h0,    4'd0);
        add_fetch(I_HALT);
        add(I_HALT, B_RUN,           16'h0,    16'h0,    4'd0);
        add(I_HALT, 14'h0,           16'h0,    16'h0,    4'd0);

        // First table row is T0, one edge after release.
        @(negedge clock);
        clear_n = 1'b1;
        foreach (tbl[i]) begin
            @(posedge clock);
            #1;
            IR = tbl[i].ir;
            @(negedge clock);
            check($sformatf("row%0d strobes", i), 32'(strb_now()), 32'(tbl[i].strb));
            check($sformatf("row%0d rin", i), 32'(Rin), 32'(tbl[i].rin));
            check($sformatf("row%0d rout", i), 32'(Rout), 32'(tbl[i].rout));
            check($sformatf("row%0d aluop", i), 32'(ALUop), 32'(tbl[i].alu));
        end
        check("or result R2", R[2], 32'h75);
        check("addi result R3", R[3], 32'h0B);
        check("ld result R1", R[1], 32'hCAFE);

        for (int i = 0; i < 20; i++) begin
            step();
            check($sformatf("halt hold %0d", i),
                  {Rin, 2'b00, strb_now()} | 32'(Rout), 32'h0);
        end

        // Illegal opcode: sticky flag, cleared only by reset
        IR = I_ILL;
        pulse_reset();
        check("ill pre T0 rst", 32'(strb_now()), 32'h0);
        for (int i = 0; i < 4; i++) step();
        check("ill T3", 32'(strb_now()), 32'(B_RUN));
        step();
        check("ill halt", 32'(strb_now()), 32'(B_ILL));
        step();
        check("ill sticky", 32'(strb_now()), 32'(B_ILL));
        pulse_reset();
        check("ill cleared", 32'(strb_now()), 32'h0);
        IR = I_NOP;
        step();
        check("ill then T0", 32'(strb_now()), 32'(F0));

        // Stop raised in T4 of add; IR garbage during fetch is ignored
        IR = I_ILL;
        pulse_reset();
        step();
        check("stop T0", 32'(strb_now()), 32'(F0));
        step();
        check("stop T1", 32'(strb_now()), 32'(F1));
        step();
        check("stop T2", 32'(strb_now()), 32'(F2));
        IR = I_ADD;
        step();
        check("stop T3 rout", 32'(Rout), 32'h0004);
        step();
        check("stop T4 rout", 32'(Rout), 32'h0008);
        check("stop T4 aluop", 32'(ALUop), 32'd2);
        Stop = 1'b1;
        step();
        check("stop T5 strobes", 32'(strb_now()), 32'(B_ZOUT | B_RUN));
        check("stop T5 rin", 32'(Rin), 32'h0002);
        step();
        check("stop halt", 32'(strb_now()), 32'h0);
        Stop = 1'b0;
        step();
        check("stop stays halted", 32'(strb_now()), 32'h0);
        check("add result R1", R[1], 32'h80);

        // Reset dropped in T6 of ld must suppress the write-back
        poke(1'b0, 8'h30, 32'hBEEF);
        IR = I_LD;
        pulse_reset();
        mon = 1'b1;
        for (int i = 0; i < 7; i++) step();
        check("ldrst T6", 32'(strb_now()), 32'(B_READ | B_MDRIN | B_RUN));
        clear_n = 1'b0;
        step();
        check("ldrst rst strobes", 32'(strb_now()), 32'h0);
        check("ldrst rst rin", 32'(Rin), 32'h0);
        clear_n = 1'b1;
        step();
        mon = 1'b0;
        check("ldrst then T0", 32'(strb_now()), 32'(F0));
        check("ldrst no rin pulse", 32'(rin_seen), 32'h0);
        check("ldrst R1 kept", R[1], 32'h80);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/control_unit.md
# control_unit

Hardwired control sequencer for the Phase-1 CPU datapath. It runs the fetch/decode/execute step sequence itself, so the per-instruction control sequences no longer have to be hand-driven from a testbench. It reads the `IR` output of `datapath` and drives that module's register-select, bus-enable, memory, ALU and PC control inputs each clock. Execution uses the same T0–T7 step timing as the datapath benches.

## Interface

Parameters:
- `NREGS`, 16, number of general registers; width of `Rin` and `Rout`.
- `CWIDTH`, 19, width of the immediate field `IR[18:0]`.

Ports:
- `clock` in 1: system clock; all state changes on the rising edge.
- `clear_n` in 1: reset, synchronous, active-low.
- `IR` in 32: instruction register contents from `datapath`.
- `Stop` in 1: level request to halt after the current instruction.
- `Rin` out 16: one-hot general register write enable.
- `Rout` out 16: one-hot general register bus drive.
- `PCin`, `PCout`, `MARin`, `MDRin`, `MDRout`, `IRin`, `Yin`, `Zlowin`, `Zlowout`, `IncPC`, `Read` out 1 each: datapath strobes.
- `Cout` out 1: drive the sign-extended `IR[18:0]` onto the bus.
- `ALUop` out 4: ALU function select.
- `Run` out 1: 1 while executing, 0 in HALT.
- `Illegal` out 1: sticky flag, set when an unknown opcode is decoded.

## Operation

Instruction fields:
- Opcode is `IR[31:27]`.
- `ra` is `IR[26:23]`, `rb` is `IR[22:19]`, `rc` is `IR[18:15]`.
- Immediate `C` is `IR[18:0]`, sign-extended in the datapath when `Cout` is 1.

Opcodes:
- `ld` 00000, `addi` 00001, `add` 00011, `sub` 00100, `and` 00101, `or` 00110, `shl` 00111, `shr` 01000, `nop` 11010, `halt` 11011.
- Every other opcode is illegal.

ALU codes: OR 0, AND 1, ADD 2, SUB 3, SHL 4, SHR 5.

States: RST, T0–T7, HALT. Outputs are Moore-style, decoded from the state and `IR`. Every strobe not listed for a state is 0.

- RST: all strobes 0, `Run`=0. Next state T0.
- T0: `PCout`, `MARin`, `IncPC`, `Zlowin`.
- T1: `Zlowout`, `PCin`, `Read`, `MDRin`.
- T2: `MDRout`, `IRin`.
- T3 (decode):
  - R-type, `addi`, `ld`: `Rout[rb]`, `Yin`; next T4.
  - `nop`: no strobes; next T0.
  - `halt` or illegal: no strobes; next HALT. Illegal also sets `Illegal`.
- T4:
  - R-type: `Rout[rc]`, `ALUop` from the opcode, `Zlowin`.
  - `addi` and `ld`: `Cout`, `ALUop`=ADD, `Zlowin`.
- T5:
  - R-type and `addi`: `Zlowout`, `Rin[ra]`; next T0.
  - `ld`: `Zlowout`, `MARin`; next T6.
- T6 (`ld`): `Read`, `MDRin`.
- T7 (`ld`): `MDRout`, `Rin[ra]`; next T0.
- HALT: all strobes 0, `Run`=0. The controller stays here until `clear_n` is low.
- `Stop`:
  - Sampled on each edge that would enter T0. If `Stop`=1, the next state is HALT instead of T0.
  - Never aborts an instruction that is in progress.
- `ALUop` is 0 in every state other than T4.
- `Rin` and `Rout` are one-hot or all-zero at all times.

## Timing

- Reset:
  - `clear_n`=0 at an edge forces state RST, clears `Illegal`, and sets all outputs to 0 and `Run`=0.
  - This takes priority over every transition, including in the middle of an instruction.
  - The first T0 occurs 1 cycle after `clear_n` returns high.
- Instruction lengths in cycles, counted T0 to the next T0:
  - `nop` 4.
  - R-type and `addi` 6.
  - `ld` 8.
  - `halt` reaches HALT at T3+1.
- Memory is combinational: `Mdatain` is valid in the same cycle that `Read`=1, and the MDR is captured at the end of that cycle.
- `IR` is sampled only in T3–T7, so changes to `IR` in T0–T2 are ignored.
- Register index 0 is an ordinary register, with no zero-register special case.

## Structure

- Package `cpu_pkg` holds the opcode constants, the ALU code constants, the state encoding enum, and the IR field position constants. The datapath ALU shares the ALU codes from this package.
- One sub-module, `reg_decoder_4to16`: a 4-bit index plus enable gives a one-hot 16-bit output. It is instantiated twice, once for `Rin` and once for `Rout`.

## Test plan

- **`or R2,R5,R6`:** set `IR`=0x312B0000 and preload R5=0x34, R6=0x45. Required: T3 `Rout`=0x0020; T4 `Rout`=0x0040 and `ALUop`=0; T5 `Rin`=0x0004; R2=0x75 at the next T0.
- **`addi R3,R4,-5`:** set `IR`=0x09A7FFFB with R4=0x10. Required: T4 `Cout`=1 and `ALUop`=2; R3=0x0B after T5.
- **`ld R1,0x10(R7)`:** set `IR`=0x00B80010 with R7=0x20 and M[0x30]=0xCAFE. Required: T5 `MARin`=1; T6 `Read`=1; T7 `Rin`=0x0002; R1=0xCAFE; instruction length 8 cycles.
- **`nop` then `halt`:** issue `nop`=0xD0000000, then `halt`=0xD8000000. Required: `nop` returns to T0 after 4 cycles; `halt` leaves `Run`=0 and all strobes 0 for 20 cycles.
- **Illegal opcode:** `IR`=0xF8000000. Required: `Illegal`=1 and HALT. `clear_n` low for 1 edge then clears `Illegal` and gives T0 on the following cycle.
- **Stop and reset races:**
  - Assert `Stop` during T4 of `add`. Required: T5 completes, then HALT with no T0.
  - Drop `clear_n` during `ld` T6. Required: no `Rin` pulse ever occurs, and the state is RST.
